// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: per-stage stall/flush and operand-forward selects for a
// 5-stage pipeline, plus a register scoreboard for variable-latency long ops.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_sb #(
    parameter int REG_NUM  = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LONG = 4,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              CpuRstN,
    input  logic              ICacheMiss,
    input  logic              DCacheMiss,
    input  logic              BranchE,
    input  logic              BranchPredictedE,
    input  logic              JalrE,
    input  logic              JalD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [1:0]        RegReadD,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              LongOpD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        RegReadE,
    input  logic              MemToRegE,
    input  logic              LongOpE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LongWbValid,
    input  logic [REG_AW-1:0] LongWbRd,
    output logic              StallF,
    output logic              FlushF,
    output logic              StallD,
    output logic              FlushD,
    output logic              StallE,
    output logic              FlushE,
    output logic              StallM,
    output logic              FlushM,
    output logic              StallW,
    output logic              FlushW,
    output logic [1:0]        Forward1E,
    output logic [1:0]        Forward2E,
    output logic              SbFull
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] StallCycCnt,
    output logic [PERF_W-1:0] FlushCnt,
    output logic [PERF_W-1:0] SbStallCnt
`endif
);

    logic [REG_NUM-1:1] busy_q, busy_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [REG_NUM-1:0] busy_eff;
    logic               wb_hit, wb_ok, issue;
    logic               sb_full, sb_haz, miss, redirect, load_use;
    logic               sel_redirect, sel_sb;
    logic [9:0]         ctl;

    // Forward source for one E operand: M beats W beats the long-op writeback bus.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src, input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (src != '0)) begin
            if (RegWriteM && (RdM == src))
                sel = 2'b10;
            else if (RegWriteW && (RdW == src))
                sel = 2'b01;
            else if (LongWbValid && (LongWbRd == src))
                sel = 2'b11;
        end
        return sel;
    endfunction

    // Hazard detection and prioritised stage controls.
    always_comb begin
        wb_hit   = LongWbValid & (LongWbRd != '0);
        busy_eff = '0;
        // A register retiring on the writeback bus this cycle is already forwardable.
        for (int r = 1; r < REG_NUM; r++)
            busy_eff[r] = busy_q[r] & ~(wb_hit & (LongWbRd == REG_AW'(r)));
        sb_full  = (out_cnt_q == CNT_W'(MAX_LONG));
        sb_haz   = (RegReadD[1] & busy_eff[Rs1D]) |
                   (RegReadD[0] & busy_eff[Rs2D]) |
                   (RegWriteD   & busy_eff[RdD])  |
                   (LongOpD     & sb_full);
        miss     = ICacheMiss | DCacheMiss;
        redirect = (BranchE ^ BranchPredictedE) | JalrE;
        load_use = MemToRegE & (RdE != '0) &
                   ((RegReadD[1] & (Rs1D == RdE)) | (RegReadD[0] & (Rs2D == RdE)));
        sel_redirect = ~miss & redirect;
        sel_sb       = ~miss & ~redirect & ~load_use & sb_haz;

        // bit order: StallF FlushF StallD FlushD StallE FlushE StallM FlushM StallW FlushW
        if (!CpuRstN)       ctl = 10'b0101010101;
        else if (miss)      ctl = 10'b1010101010;
        else if (redirect)  ctl = 10'b0001010000;
        else if (load_use)  ctl = 10'b1010010000;
        else if (sb_haz)    ctl = 10'b1010010000;
        else if (JalD)      ctl = 10'b0001000000;
        else                ctl = 10'b0000000000;
    end

    assign {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW} = ctl;

    // Operand forwarding selects, parked on the register file during reset.
    always_comb begin
        Forward1E = 2'b00;
        Forward2E = 2'b00;
        if (CpuRstN) begin
            Forward1E = fwd_sel(Rs1E, RegReadE[1]);
            Forward2E = fwd_sel(Rs2E, RegReadE[0]);
        end
    end

    assign SbFull = CpuRstN & sb_full;

    // Scoreboard next state: clear on writeback first so a same-register issue wins.
    always_comb begin
        issue     = LongOpE & ~ctl[5] & (RdE != '0);
        wb_ok     = wb_hit & (out_cnt_q != '0);
        busy_d    = busy_q;
        out_cnt_d = out_cnt_q;
        for (int r = 1; r < REG_NUM; r++) begin
            if (wb_ok && (LongWbRd == REG_AW'(r))) busy_d[r] = 1'b0;
            if (issue && (RdE == REG_AW'(r)))      busy_d[r] = 1'b1;
        end
        case ({issue, wb_ok})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Scoreboard registers.
    always_ff @(posedge clk or negedge CpuRstN) begin
        if (!CpuRstN) begin
            busy_q    <= '0;
            out_cnt_q <= '0;
        end else begin
            busy_q    <= busy_d;
            out_cnt_q <= out_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
    logic [PERF_W-1:0] flush_q, flush_d;
    logic [PERF_W-1:0] sb_stall_q, sb_stall_d;

    // Saturating event counters.
    always_comb begin
        stall_cyc_d = stall_cyc_q;
        flush_d     = flush_q;
        sb_stall_d  = sb_stall_q;
        if (ctl[9] && (stall_cyc_q != '1))  stall_cyc_d = stall_cyc_q + PERF_W'(1);
        if (sel_redirect && (flush_q != '1)) flush_d    = flush_q + PERF_W'(1);
        if (sel_sb && (sb_stall_q != '1))    sb_stall_d = sb_stall_q + PERF_W'(1);
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge CpuRstN) begin
        if (!CpuRstN) begin
            stall_cyc_q <= '0;
            flush_q     <= '0;
            sb_stall_q  <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_q     <= flush_d;
            sb_stall_q  <= sb_stall_d;
        end
    end

    assign StallCycCnt = stall_cyc_q;
    assign FlushCnt    = flush_q;
    assign SbStallCnt  = sb_stall_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb_hazard_ctrl_sb: directed scenarios plus randomized traffic, each cycle
// compared against a scoreboard model built from the priority rules.
module tb_hazard_ctrl_sb;

    localparam int MAX_LONG = 4;

    logic       clk;
    logic       CpuRstN;
    logic       ICacheMiss, DCacheMiss, BranchE, BranchPredictedE, JalrE, JalD;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongWbRd;
    logic [1:0] RegReadD, RegReadE;
    logic       RegWriteD, LongOpD, MemToRegE, LongOpE;
    logic       RegWriteM, RegWriteW, LongWbValid;
    logic       StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW;
    logic [1:0] Forward1E, Forward2E;
    logic       SbFull;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycCnt, FlushCnt, SbStallCnt;
`endif

    hazard_ctrl_sb dut (
        .clk(clk), .CpuRstN(CpuRstN),
        .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .BranchPredictedE(BranchPredictedE), .JalrE(JalrE), .JalD(JalD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD), .RdD(RdD),
        .RegWriteD(RegWriteD), .LongOpD(LongOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegReadE(RegReadE),
        .MemToRegE(MemToRegE), .LongOpE(LongOpE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LongWbValid(LongWbValid), .LongWbRd(LongWbRd),
        .StallF(StallF), .FlushF(FlushF), .StallD(StallD), .FlushD(FlushD),
        .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
        .StallW(StallW), .FlushW(FlushW),
        .Forward1E(Forward1E), .Forward2E(Forward2E), .SbFull(SbFull)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycCnt(StallCycCnt), .FlushCnt(FlushCnt), .SbStallCnt(SbStallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    bit      m_busy [32];
    int      m_cnt;
    longint  m_stall_cyc, m_flush, m_sb_stall;

    logic [9:0] exp_ctl, act_ctl;
    logic [1:0] exp_f1, exp_f2, act_f1, act_f2;
    logic       exp_full, act_full;
    bit         exp_miss, exp_redir_sel, exp_sb_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] act_stall_cyc, act_flush, act_sb_stall;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_busy(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !(LongWbValid && (LongWbRd == r));
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src, input logic used);
        if (!used || src == 0) return 2'd0;
        if (RegWriteM && RdM == src) return 2'd2;
        if (RegWriteW && RdW == src) return 2'd1;
        if (LongWbValid && LongWbRd == src) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_outputs();
        bit redir, lu, sbh;
        exp_miss = ICacheMiss || DCacheMiss;
        redir = (BranchE != BranchPredictedE) || JalrE;
        lu = MemToRegE && RdE != 0 &&
             ((RegReadD[1] && Rs1D == RdE) || (RegReadD[0] && Rs2D == RdE));
        sbh = (RegReadD[1] && is_busy(Rs1D)) || (RegReadD[0] && is_busy(Rs2D)) ||
              (RegWriteD && is_busy(RdD)) || (LongOpD && m_cnt == MAX_LONG);
        exp_redir_sel = 0;
        exp_sb_sel    = 0;
        if (!CpuRstN) begin
            exp_ctl = 10'b0101010101; exp_f1 = 0; exp_f2 = 0; exp_full = 0;
        end else begin
            if (exp_miss)     exp_ctl = 10'b1010101010;
            else if (redir)   begin exp_ctl = 10'b0001010000; exp_redir_sel = 1; end
            else if (lu)      exp_ctl = 10'b1010010000;
            else if (sbh)     begin exp_ctl = 10'b1010010000; exp_sb_sel = 1; end
            else if (JalD)    exp_ctl = 10'b0001000000;
            else              exp_ctl = 10'b0000000000;
            exp_f1   = model_fwd(Rs1E, RegReadE[1]);
            exp_f2   = model_fwd(Rs2E, RegReadE[0]);
            exp_full = (m_cnt == MAX_LONG);
        end
    endtask

    task automatic model_advance();
        if (!CpuRstN) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_cnt = 0; m_stall_cyc = 0; m_flush = 0; m_sb_stall = 0;
        end else begin
            if (LongWbValid && LongWbRd != 0 && m_cnt > 0) begin
                m_busy[LongWbRd] = 0;
                m_cnt--;
            end
            if (LongOpE && !exp_miss && RdE != 0) begin
                m_busy[RdE] = 1;
                m_cnt++;
            end
            if (exp_ctl[9])    m_stall_cyc++;
            if (exp_redir_sel) m_flush++;
            if (exp_sb_sel)    m_sb_stall++;
        end
    endtask

    // One cycle: sample mid-cycle, compare with the model, clock, advance the model.
    task automatic step(input string tag);
        #2;
        act_ctl  = {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW};
        act_f1   = Forward1E;
        act_f2   = Forward2E;
        act_full = SbFull;
        model_outputs();
        check_val({tag, "_ctl"}, 32'(act_ctl), 32'(exp_ctl));
        check_val({tag, "_f1"}, 32'(act_f1), 32'(exp_f1));
        check_val({tag, "_f2"}, 32'(act_f2), 32'(exp_f2));
        check_val({tag, "_full"}, 32'(act_full), 32'(exp_full));
`ifdef HAZARD_PERF_CNT_EN
        act_stall_cyc = StallCycCnt;
        act_flush     = FlushCnt;
        act_sb_stall  = SbStallCnt;
        check_val({tag, "_pstall"}, act_stall_cyc, 32'(m_stall_cyc));
        check_val({tag, "_pflush"}, act_flush, 32'(m_flush));
        check_val({tag, "_psb"}, act_sb_stall, 32'(m_sb_stall));
`endif
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ICacheMiss = 0; DCacheMiss = 0; BranchE = 0; BranchPredictedE = 0; JalrE = 0; JalD = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; RegReadD = 0; RegWriteD = 0; LongOpD = 0;
        Rs1E = 0; Rs2E = 0; RdE = 0; RegReadE = 0; MemToRegE = 0; LongOpE = 0;
        RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0; LongWbValid = 0; LongWbRd = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        CpuRstN = 0;
        step("rst");
        check_val("rst_ctl_lit", 32'(act_ctl), 32'(10'b0101010101));
        CpuRstN = 1;
    endtask

    task automatic rand_inputs();
        ICacheMiss       = ($urandom_range(0, 19) == 0);
        DCacheMiss       = ($urandom_range(0, 19) == 0);
        BranchE          = 1'($urandom_range(0, 1));
        BranchPredictedE = ($urandom_range(0, 7) == 0) ? ~BranchE : BranchE;
        JalrE            = ($urandom_range(0, 15) == 0);
        JalD             = ($urandom_range(0, 7) == 0);
        Rs1D             = 5'($urandom_range(0, 7));
        Rs2D             = 5'($urandom_range(0, 7));
        RdD              = 5'($urandom_range(0, 7));
        RegReadD         = 2'($urandom_range(0, 3));
        RegWriteD        = 1'($urandom_range(0, 1));
        LongOpD          = ($urandom_range(0, 3) == 0);
        Rs1E             = 5'($urandom_range(0, 7));
        Rs2E             = 5'($urandom_range(0, 7));
        RdE              = 5'($urandom_range(0, 7));
        RegReadE         = 2'($urandom_range(0, 3));
        MemToRegE        = ($urandom_range(0, 3) == 0);
        LongOpE          = (m_cnt < MAX_LONG) && ($urandom_range(0, 2) == 0);
        RdM              = 5'($urandom_range(0, 7));
        RdW              = 5'($urandom_range(0, 7));
        RegWriteM        = 1'($urandom_range(0, 1));
        RegWriteW        = 1'($urandom_range(0, 1));
        LongWbValid      = ($urandom_range(0, 2) == 0);
        LongWbRd         = 5'($urandom_range(0, 7));
        CpuRstN          = ($urandom_range(0, 99) != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        CpuRstN = 0;
        m_cnt = 0; m_stall_cyc = 0; m_flush = 0; m_sb_stall = 0;
        @(negedge clk);

        // reset in the middle of activity clears busy bits and the counter
        do_reset();
        LongOpE = 1; RdE = 5; step("iss5");
        RdE = 6; step("iss6");
        clear_inputs();
        CpuRstN = 0; step("midrst");
        check_val("midrst_ctl_lit", 32'(act_ctl), 32'(10'b0101010101));
        check_val("midrst_fwd_lit", 32'({act_f1, act_f2}), 32'd0);
        CpuRstN = 1;
        RegReadD = 2'b10; Rs1D = 5; step("busy_clr");
        check_val("busy_clr_lit", 32'(act_ctl), 32'd0);
        clear_inputs();
        LongOpE = 1; RdE = 1; step("re1");
        RdE = 2; step("re2");
        clear_inputs(); step("cnt_clr");
        check_val("cnt_clr_lit", 32'(act_full), 32'd0);

        // RAW on a long op, released by its writeback, forwarded from the long bus
        do_reset();
        LongOpE = 1; RdE = 7; step("raw_iss");
        clear_inputs();
        RegReadD = 2'b10; Rs1D = 7;
        for (int i = 0; i < 3; i++) begin
            step("raw_stall");
            check_val("raw_stall_lit", 32'(act_ctl), 32'(10'b1010010000));
        end
        LongWbValid = 1; LongWbRd = 7; Rs1E = 7; RegReadE = 2'b10;
        step("raw_wb");
        check_val("raw_wb_ctl_lit", 32'(act_ctl), 32'd0);
        check_val("raw_wb_fwd_lit", 32'(act_f1), 32'd3);

        // scoreboard full, then simultaneous writeback and issue
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            LongOpE = 1; RdE = 5'(r); step("fill");
        end
        clear_inputs();
        LongOpD = 1; step("full");
        check_val("full_lit", 32'(act_full), 32'd1);
        check_val("full_ctl_lit", 32'(act_ctl), 32'(10'b1010010000));
        clear_inputs();
        LongWbValid = 1; LongWbRd = 2; LongOpE = 1; RdE = 6; step("wb_iss");
        clear_inputs();
        RegReadD = 2'b01; Rs2D = 6; step("full_hold");
        check_val("full_hold_lit", 32'(act_full), 32'd1);
        check_val("x6_busy_lit", 32'(act_ctl), 32'(10'b1010010000));
        Rs2D = 2; step("x2_free");
        check_val("x2_free_lit", 32'(act_ctl), 32'd0);

        // cache miss outranks mispredict and scoreboard; no issue while frozen
        clear_inputs();
        DCacheMiss = 1; BranchE = 1; BranchPredictedE = 0; RegReadD = 2'b10; Rs1D = 3;
        LongOpE = 1; RdE = 10; step("prio_miss");
        check_val("prio_miss_lit", 32'(act_ctl), 32'(10'b1010101010));
        DCacheMiss = 0; LongOpE = 0; step("prio_redir");
        check_val("prio_redir_lit", 32'(act_ctl), 32'(10'b0001010000));
        clear_inputs();
        RegReadD = 2'b10; Rs1D = 10; step("no_issue");
        check_val("no_issue_lit", 32'(act_ctl), 32'd0);
        check_val("no_issue_cnt_lit", 32'(act_full), 32'd1);

        // forwarding priority and x0 handling
        do_reset();
        RdM = 9; RdW = 9; LongWbRd = 9; RegWriteM = 1; RegWriteW = 1; LongWbValid = 1;
        Rs2E = 9; RegReadE = 2'b01; step("fwd_m");
        check_val("fwd_m_lit", 32'(act_f2), 32'd2);
        RegWriteM = 0; step("fwd_w");
        check_val("fwd_w_lit", 32'(act_f2), 32'd1);
        RegWriteW = 0; step("fwd_l");
        check_val("fwd_l_lit", 32'(act_f2), 32'd3);
        RegReadE = 2'b00; step("fwd_off");
        check_val("fwd_off_lit", 32'(act_f2), 32'd0);
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            LongOpE = 1; RdE = 0; step("x0_iss");
        end
        clear_inputs();
        RegWriteD = 1; RdD = 0; LongOpD = 1; step("x0_chk");
        check_val("x0_ctl_lit", 32'(act_ctl), 32'd0);
        check_val("x0_full_lit", 32'(act_full), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        LongOpE = 1; RdE = 7; step("perf_iss");
        clear_inputs();
        RegReadD = 2'b10; Rs1D = 7;
        for (int i = 0; i < 3; i++) step("perf_sb");
        clear_inputs();
        BranchE = 1; step("perf_br");
        clear_inputs(); step("perf_chk");
        check_val("perf_sb_lit", act_sb_stall, 32'd3);
        check_val("perf_flush_lit", act_flush, 32'd1);
        check_val("perf_stall_lit", act_stall_cyc, 32'd3);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
